// File: rtl/mux_nto1_stream.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_stream
// Description : N-input valid/ready stream multiplexer with a registered channel
//               select and one registered output stage. Defining MUX_RR_EN adds
//               an rr_mode input that enables round-robin channel rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_stream #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef MUX_RR_EN
    input  logic                    rr_mode,
`endif
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_load,
    output logic [SEL_W-1:0]        cur_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

    logic [SEL_W-1:0]  r_cur_sel;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;

    logic [WIDTH-1:0]  w_ch_data [NUM_IN];
    logic [NUM_IN-1:0] w_in_ready;
    logic              w_out_free;
    logic              w_cur_valid;
    logic              w_accept;
    logic              w_sel_legal;
    logic [SEL_W-1:0]  w_sel_next;

    generate
        for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
            assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Ready depends only on the output register and the select, never on in_valid.
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_cur_valid = in_valid[r_cur_sel];
    assign w_accept    = w_cur_valid && w_out_free;
    assign w_sel_legal = ({1'b0, sel} < c_num_in);

    always_comb begin
        w_in_ready            = '0;
        w_in_ready[r_cur_sel] = w_out_free;
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] w_rr_next;
    logic [SEL_W-1:0] w_rr_cand;
    logic             w_rr_hit;
    int               w_rr_idx;

    // First valid channel scanning cyclically from cur_sel+1; plain +1 when none is valid.
    always_comb begin
        w_rr_next = (r_cur_sel == SEL_W'(NUM_IN-1)) ? '0 : r_cur_sel + SEL_W'(1);
        w_rr_hit  = 1'b0;
        w_rr_idx  = 0;
        w_rr_cand = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            w_rr_idx  = (int'(r_cur_sel) + i) % NUM_IN;
            w_rr_cand = w_rr_idx[SEL_W-1:0];
            if (!w_rr_hit && in_valid[w_rr_cand]) begin
                w_rr_next = w_rr_cand;
                w_rr_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_next = r_cur_sel;
        if (rr_mode) begin
            if (w_accept || !w_cur_valid)
                w_sel_next = w_rr_next;
        end else if (sel_load && w_sel_legal) begin
            w_sel_next = sel;
        end
    end
`else
    always_comb begin
        w_sel_next = r_cur_sel;
        if (sel_load && w_sel_legal)
            w_sel_next = sel;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_sel   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_cur_sel <= w_sel_next;
            if (w_accept) begin
                r_out_data  <= w_ch_data[r_cur_sel];
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign cur_sel   = r_cur_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
